// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pkg
// Description : Shared definitions for the external SRAM access arbiter:
//               FSM state encoding, requester indices, default bus widths
//               and the matcher/reference region base address.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

    localparam int ADDR_W_DEF   = 20;
    localparam int DATA_W_DEF   = 16;
    localparam int NUM_REQ      = 3;
    localparam int WAIT_W       = 4;

    // Requester indices into the REQ/GNT/DONE vectors
    localparam int REQ_REC      = 0;   // waveform recorder (writes)
    localparam int REQ_MAT      = 1;   // matcher (reads and writes)
    localparam int REQ_USB      = 2;   // USB readout (reads)

    // First word of the matcher/reference region in SRAM
    localparam int MAT_REF_BASE = 262144;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_RSTRB = 3'd2,
        ST_WSTRB = 3'd3,
        ST_RECOV = 3'd4
    } arb_state_t;

endpackage : sram_arb_pkg
`default_nettype wire

// File: rtl/sram_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pick
// Description : Combinational winner selection. Recorder has fixed top
//               priority; matcher and USB share a round-robin tie breaker.
// Ports       : i_req    - per-requester request level
//               i_rr_ptr - 0: matcher wins a tie, 1: USB wins a tie
//               o_win    - one-hot winner (all zero when nothing requested)
//               o_valid  - at least one requester is asking
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_rr_ptr,
    output logic [NUM_REQ-1:0] o_win,
    output logic               o_valid
);

    always_comb begin
        o_win = '0;
        if (i_req[REQ_REC]) begin
            o_win[REQ_REC] = 1'b1;
        end else if (i_req[REQ_MAT] && (!i_req[REQ_USB] || !i_rr_ptr)) begin
            o_win[REQ_MAT] = 1'b1;
        end else if (i_req[REQ_USB]) begin
            o_win[REQ_USB] = 1'b1;
        end
    end

    assign o_valid = |i_req;

endmodule : sram_arb_pick
`default_nettype wire

// File: rtl/sram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_access_arbiter
// Description : Sole owner of the external 16-bit async SRAM. Serialises word
//               accesses from recorder (0), matcher (1) and USB readout (2)
//               and generates all strobe timing. Every pad is registered.
// Ports       : CLK, RST            - clock, synchronous active-high reset
//               REQ/REQ_WE          - per-requester request level / write flag
//               REQ_ADDR/REQ_WDATA  - per-requester packed address / data
//               GNT/DONE            - one-cycle accept / complete pulses
//               RDATA               - read data, valid with DONE of a read
//               SRAM_*              - SRAM address, data and strobes
// Revision    : 1.0 - initial release
// ============================================================================
module sram_access_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NUM_REQ-1:0]        REQ,
    input  logic [NUM_REQ-1:0]        REQ_WE,
    input  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR,
    input  logic [NUM_REQ*DATA_W-1:0] REQ_WDATA,
    output logic [NUM_REQ-1:0]        GNT,
    output logic [NUM_REQ-1:0]        DONE,
    output logic [DATA_W-1:0]         RDATA,
    output logic [ADDR_W-1:0]         SRAM_ADDR,
    inout  wire  [DATA_W-1:0]         SRAM_DQ,
    output logic                      SRAM_OE_N,
    output logic                      SRAM_WE_N,
    output logic                      SRAM_CE1_N,
    output logic                      SRAM_CE2,
    output logic                      SRAM_BHE_N,
    output logic                      SRAM_BLE_N
);

    // Counter runs down to zero, so load with the strobe length minus one
    localparam logic [WAIT_W-1:0] C_RD_LOAD = WAIT_W'(RD_WAIT - 1);
    localparam logic [WAIT_W-1:0] C_WR_LOAD = WAIT_W'(WR_WAIT - 1);

    arb_state_t          state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                rr_q, rr_d;
    logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0]   lat_wdata_q, lat_wdata_d;
    logic                lat_we_q, lat_we_d;
    logic [NUM_REQ-1:0]  lat_sel_q, lat_sel_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;
    logic                sel_q, sel_d;       // chip + both byte lanes selected
    logic                dq_oe_q, dq_oe_d;

    logic [NUM_REQ-1:0]  w_win;
    logic                w_valid;
    logic                w_arb_ok;
    logic                w_strobe_end;

    sram_arb_pick u_pick (
        .i_req    (REQ),
        .i_rr_ptr (rr_q),
        .o_win    (w_win),
        .o_valid  (w_valid)
    );

    assign w_arb_ok     = ((state_q == ST_IDLE) || (state_q == ST_RECOV)) && w_valid;
    assign w_strobe_end = ((state_q == ST_RSTRB) || (state_q == ST_WSTRB)) && (wait_q == '0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            rr_q        <= 1'b0;          // matcher preferred after reset
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            lat_we_q    <= 1'b0;
            lat_sel_q   <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
            addr_q      <= '0;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            sel_q       <= 1'b0;
            dq_oe_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            rr_q        <= rr_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            lat_we_q    <= lat_we_d;
            lat_sel_q   <= lat_sel_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            addr_q      <= addr_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            sel_q       <= sel_d;
            dq_oe_q     <= dq_oe_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic, wait counter, request latches
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        rr_d        = rr_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        lat_we_d    = lat_we_q;
        lat_sel_d   = lat_sel_q;

        case (state_q)
            ST_IDLE: begin
                if (w_valid) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                state_d = lat_we_q ? ST_WSTRB : ST_RSTRB;
                wait_d  = lat_we_q ? C_WR_LOAD : C_RD_LOAD;
            end
            ST_RSTRB, ST_WSTRB: begin
                if (wait_q == '0) state_d = ST_RECOV;
                else              wait_d  = wait_q - 1'b1;
            end
            ST_RECOV: begin
                state_d = w_valid ? ST_SETUP : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_arb_ok) begin
            lat_sel_d = w_win;
            lat_we_d  = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_win[i]) begin
                    lat_addr_d  = REQ_ADDR[i*ADDR_W +: ADDR_W];
                    lat_wdata_d = REQ_WDATA[i*DATA_W +: DATA_W];
                    lat_we_d    = REQ_WE[i];
                end
            end
            // Tie breaker always points away from the last served of 1/2
            if (w_win[REQ_MAT]) rr_d = 1'b1;
            if (w_win[REQ_USB]) rr_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output decode: pads are registered, so decode from the next state
    // ------------------------------------------------------------------
    always_comb begin
        gnt_d   = w_arb_ok ? w_win : '0;
        done_d  = w_strobe_end ? lat_sel_q : '0;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        sel_d   = 1'b1;
        dq_oe_d = 1'b0;

        // Capture on the edge that ends the last OE_N-low cycle
        if ((state_q == ST_RSTRB) && (wait_q == '0)) rdata_d = SRAM_DQ;

        case (state_d)
            ST_IDLE:  sel_d   = 1'b0;
            ST_SETUP: addr_d  = lat_addr_d;
            ST_RSTRB: oe_n_d  = 1'b0;
            ST_WSTRB: begin
                we_n_d  = 1'b0;
                dq_oe_d = 1'b1;
            end
            // Keep write data on the bus one extra cycle for hold time
            ST_RECOV: dq_oe_d = lat_we_q;
            default:  sel_d   = 1'b0;
        endcase
    end

    assign GNT        = gnt_q;
    assign DONE       = done_q;
    assign RDATA      = rdata_q;
    assign SRAM_ADDR  = addr_q;
    assign SRAM_OE_N  = oe_n_q;
    assign SRAM_WE_N  = we_n_q;
    assign SRAM_CE1_N = ~sel_q;
    assign SRAM_CE2   = sel_q;
    assign SRAM_BHE_N = ~sel_q;
    assign SRAM_BLE_N = ~sel_q;
    assign SRAM_DQ    = dq_oe_q ? lat_wdata_q : {DATA_W{1'bz}};

endmodule : sram_access_arbiter
`default_nettype wire

// File: tb/tb_sram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_access_arbiter
// Description : Directed bench for sram_access_arbiter. Stimulus pushes the
//               expected GNT/DONE events into a scoreboard queue; a monitor
//               pops and compares whenever the DUT pulses GNT or DONE. A
//               second instance built with RD_WAIT=4 covers long strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_access_arbiter;

    localparam int AW = 20;
    localparam int DW = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic [2:0]    REQ, REQ_WE, GNT, DONE;
    logic [3*AW-1:0] REQ_ADDR;
    logic [3*DW-1:0] REQ_WDATA;
    logic [DW-1:0] RDATA;
    logic [AW-1:0] SRAM_ADDR;
    wire  [DW-1:0] SRAM_DQ;
    logic          SRAM_OE_N, SRAM_WE_N, SRAM_CE1_N, SRAM_CE2, SRAM_BHE_N, SRAM_BLE_N;

    // Second instance with a 4-cycle read strobe
    logic [2:0]    r4_req, r4_req_we, r4_gnt, r4_done;
    logic [3*AW-1:0] r4_req_addr;
    logic [3*DW-1:0] r4_req_wdata;
    logic [DW-1:0] r4_rdata;
    logic [AW-1:0] r4_addr;
    wire  [DW-1:0] r4_dq;
    logic          r4_oe_n, r4_we_n, r4_ce1_n, r4_ce2, r4_bhe_n, r4_ble_n;

    always #4 CLK = ~CLK;

    sram_access_arbiter dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
        .REQ_WDATA(REQ_WDATA), .GNT(GNT), .DONE(DONE), .RDATA(RDATA),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ), .SRAM_OE_N(SRAM_OE_N),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_CE1_N(SRAM_CE1_N), .SRAM_CE2(SRAM_CE2),
        .SRAM_BHE_N(SRAM_BHE_N), .SRAM_BLE_N(SRAM_BLE_N)
    );

    sram_access_arbiter #(.RD_WAIT(4)) dut4 (
        .CLK(CLK), .RST(RST), .REQ(r4_req), .REQ_WE(r4_req_we), .REQ_ADDR(r4_req_addr),
        .REQ_WDATA(r4_req_wdata), .GNT(r4_gnt), .DONE(r4_done), .RDATA(r4_rdata),
        .SRAM_ADDR(r4_addr), .SRAM_DQ(r4_dq), .SRAM_OE_N(r4_oe_n),
        .SRAM_WE_N(r4_we_n), .SRAM_CE1_N(r4_ce1_n), .SRAM_CE2(r4_ce2),
        .SRAM_BHE_N(r4_bhe_n), .SRAM_BLE_N(r4_ble_n)
    );

    // ---------------- SRAM models ----------------
    // Sparse model: the few addresses used map onto distinct slots
    logic [DW-1:0] mem [0:255];
    wire  [7:0]    w_midx = {SRAM_ADDR[18], SRAM_ADDR[6:0]};

    assign SRAM_DQ = (!SRAM_OE_N && SRAM_WE_N && !SRAM_CE1_N && SRAM_CE2) ? mem[w_midx] : 16'bz;

    always @(posedge CLK) begin
        if (!SRAM_WE_N && !SRAM_CE1_N && SRAM_CE2) mem[w_midx] <= SRAM_DQ;
    end

    // Second model returns a fixed function of the address
    assign r4_dq = (!r4_oe_n && r4_we_n && !r4_ce1_n && r4_ce2) ? (r4_addr[15:0] ^ 16'hA5A5) : 16'bz;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        is_done;
        logic [1:0]  idx;
        logic        chk_data;
        logic [15:0] data;
        logic [31:0] cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic push(input logic dn, input int idx, input int at, input logic ck, input logic [15:0] d);
        exp_t x;
        x.is_done  = dn;
        x.idx      = 2'(idx);
        x.chk_data = ck;
        x.data     = d;
        x.cyc      = 32'(at);
        sb.push_back(x);
    endtask

    // Monitor: pops one expected event per GNT/DONE pulse; also checks
    // that OE/WE never overlap and DQ is never driven while OE_N is low.
    always @(negedge CLK) begin
        if (!RST) begin
            if (GNT != 3'b000 || DONE != 3'b000) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", {26'b0, GNT, DONE}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind", {31'b0, DONE != 3'b000}, {31'b0, e.is_done});
                    chk("event_who", {29'b0, e.is_done ? DONE : GNT}, 32'(3'b001 << e.idx));
                    chk("event_cycle", 32'(cyc), e.cyc);
                    if (e.is_done && e.chk_data) chk("rdata", {16'b0, RDATA}, {16'b0, e.data});
                end
            end
            chk("oe_we_overlap", {31'b0, !SRAM_OE_N && !SRAM_WE_N}, 32'h0);
            chk("dq_during_oe", {31'b0, dut.dq_oe_q && !SRAM_OE_N}, 32'h0);
        end
    end

    // Single access with pin-level checks over cycles 1..5 (edge 0 = request sampled)
    task automatic access(input int idx, input logic we, input logic [19:0] addr,
                          input logic [15:0] wd, input logic [15:0] exp_rd);
        int  t;
        logic strobe;
        t = cyc;
        REQ_WE[idx]                = we;
        REQ_ADDR[idx*AW +: AW]     = addr;
        REQ_WDATA[idx*DW +: DW]    = wd;
        REQ[idx]                   = 1'b1;
        push(1'b0, idx, t + 1, 1'b0, 16'h0);
        push(1'b1, idx, t + 4, !we, exp_rd);
        for (int n = 1; n <= 5; n++) begin
            @(negedge CLK);
            if (n == 1) REQ[idx] = 1'b0;
            strobe = (n == 2 || n == 3);
            chk("oe_n", {31'b0, SRAM_OE_N}, {31'b0, !(strobe && !we)});
            chk("we_n", {31'b0, SRAM_WE_N}, {31'b0, !(strobe && we)});
            chk("dq_drive", {31'b0, dut.dq_oe_q}, {31'b0, we && n >= 2 && n <= 4});
            if (n <= 4) begin
                chk("ce1_n_active", {31'b0, SRAM_CE1_N}, 32'h0);
                chk("sram_addr", {12'b0, SRAM_ADDR}, {12'b0, addr});
            end else begin
                chk("ce1_n_idle", {31'b0, SRAM_CE1_N}, 32'h1);
                chk("ce2_idle", {31'b0, SRAM_CE2}, 32'h0);
            end
            if (we && strobe) chk("dq_wdata", {16'b0, SRAM_DQ}, {16'b0, wd});
        end
    endtask

    initial begin
        int t;
        RST = 1'b1;
        REQ = '0; REQ_WE = '0; REQ_ADDR = '0; REQ_WDATA = '0;
        r4_req = '0; r4_req_we = '0; r4_req_addr = '0; r4_req_wdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        mem[8'h10] = 16'h1234;

        // ---- reset ----
        repeat (2) @(negedge CLK);
        chk("rst_oe_n", {31'b0, SRAM_OE_N}, 32'h1);
        chk("rst_we_n", {31'b0, SRAM_WE_N}, 32'h1);
        chk("rst_ce1_n", {31'b0, SRAM_CE1_N}, 32'h1);
        chk("rst_ce2", {31'b0, SRAM_CE2}, 32'h0);
        chk("rst_bytes_n", {30'b0, SRAM_BHE_N, SRAM_BLE_N}, 32'h3);
        chk("rst_gnt_done", {26'b0, GNT, DONE}, 32'h0);
        chk("rst_rdata", {16'b0, RDATA}, 32'h0);
        chk("rst_addr", {12'b0, SRAM_ADDR}, 32'h0);
        chk("rst_dq", {31'b0, dut.dq_oe_q}, 32'h0);
        RST = 1'b0;
        @(negedge CLK);

        // ---- single read, write, read-back ----
        access(2, 1'b0, 20'h00010, 16'h0000, 16'h1234);
        access(0, 1'b1, 20'h40000, 16'h03FF, 16'h0000);
        chk("mem_written", {16'b0, mem[8'h80]}, 32'h03FF);
        access(2, 1'b0, 20'h40000, 16'h0000, 16'h03FF);

        // ---- arbitration: 0 first, then 1/2 alternate, 4-cycle period ----
        REQ_WE = 3'b001;
        REQ_ADDR  = {20'h40000, 20'h00010, 20'h00030};
        REQ_WDATA = {16'h0, 16'h0, 16'h5555};
        t = cyc;
        REQ = 3'b111;
        push(1'b0, 0, t + 1,  1'b0, 16'h0);    push(1'b1, 0, t + 4,  1'b0, 16'h0);
        push(1'b0, 1, t + 5,  1'b0, 16'h0);    push(1'b1, 1, t + 8,  1'b1, 16'h1234);
        push(1'b0, 2, t + 9,  1'b0, 16'h0);    push(1'b1, 2, t + 12, 1'b1, 16'h03FF);
        push(1'b0, 1, t + 13, 1'b0, 16'h0);    push(1'b1, 1, t + 16, 1'b1, 16'h1234);
        push(1'b0, 2, t + 17, 1'b0, 16'h0);    push(1'b1, 2, t + 20, 1'b1, 16'h03FF);
        @(negedge CLK);
        REQ[0] = 1'b0;
        while (cyc < t + 17) @(negedge CLK);
        REQ = 3'b000;
        while (cyc < t + 22) @(negedge CLK);
        chk("mem_rec_write", {16'b0, mem[8'h30]}, 32'h5555);

        // ---- reset during write strobe: no DONE, pins back to reset ----
        t = cyc;
        REQ_WE[0] = 1'b1;
        REQ_ADDR[0 +: AW] = 20'h00020;
        REQ_WDATA[0 +: DW] = 16'hBEEF;
        REQ[0] = 1'b1;
        push(1'b0, 0, t + 1, 1'b0, 16'h0);
        @(negedge CLK);
        REQ[0] = 1'b0;
        @(negedge CLK);
        chk("we_n_before_rst", {31'b0, SRAM_WE_N}, 32'h0);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("abort_we_n", {31'b0, SRAM_WE_N}, 32'h1);
        chk("abort_dq", {31'b0, dut.dq_oe_q}, 32'h0);
        chk("abort_ce1_n", {31'b0, SRAM_CE1_N}, 32'h1);
        chk("abort_ce2", {31'b0, SRAM_CE2}, 32'h0);
        repeat (5) @(negedge CLK);

        // ---- RD_WAIT=4 instance: matcher read ----
        r4_req_addr[AW +: AW] = 20'h40123;
        r4_req[1] = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            @(negedge CLK);
            if (n == 1) r4_req = 3'b000;
            chk("rw4_oe_n", {31'b0, r4_oe_n}, {31'b0, !(n >= 2 && n <= 5)});
            chk("rw4_gnt", {29'b0, r4_gnt}, (n == 1) ? 32'h2 : 32'h0);
            chk("rw4_done", {29'b0, r4_done}, (n == 6) ? 32'h2 : 32'h0);
            if (n == 6) chk("rw4_rdata", {16'b0, r4_rdata}, 32'hA486);
        end

        repeat (4) @(negedge CLK);
        chk("sb_drain", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Watchdog so the run always ends on its own
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_sram_access_arbiter
`default_nettype wire
